benchmark_sequencer: RTL and testbench
======================================

# benchmark_sequencer

Synthesizable, parametrised benchmark driver for the pipelined CPU. It steps `test_selector` through a contiguous range of benchmark IDs. For each benchmark it holds the CPU in reset, releases it for a bounded run window, then re-asserts reset. Each run ends early on a CPU `halt` indication, and the sequencer reports per-benchmark cycle count and timeout status. It sits beside `cpu`, drives that block's `reset` and `test_selector`, and replaces hand-written stimulus loops in on-board and simulation regressions.

## Interface
Parameters:
- `NUM_TESTS`, 12: number of benchmarks run per sequence (≥1).
- `SEL_W`, 4: width of `test_selector`.
- `FIRST_SEL`, 1: selector value of the first benchmark. `FIRST_SEL+NUM_TESTS-1` must fit in `SEL_W`; violation is an elaboration error.
- `RESET_CYCLES`, 1: cycles `cpu_reset` is held high before each run (≥1).
- `RUN_CYCLES`, 16: maximum run-window length in cycles (≥1).
- `CNT_W`, 8: cycle-counter width. `RUN_CYCLES < 2**CNT_W` is an elaboration check.

Ports:
- `clk` input 1: the single clock.
- `reset` input 1: synchronous, active-high; returns the block to IDLE.
- `start` input 1: a one-cycle pulse in IDLE or DONE begins a sequence.
- `halt` input 1: CPU end-of-program indication; sampled only in RUN.
- `cpu_reset` output 1: drives `cpu.reset`.
- `test_selector` output SEL_W: drives `cpu.test_selector`.
- `running` output 1: high while in RUN.
- `result_valid` output 1: one-cycle strobe per completed benchmark.
- `result_sel` output SEL_W: selector of the reported benchmark.
- `result_cycles` output CNT_W: number of RUN cycles consumed.
- `result_timeout` output 1: the run hit `RUN_CYCLES` without halt.
- `done` output 1: high after the last benchmark until `start` or `reset`.

## Operation
- Reset values: state=IDLE, `cpu_reset`=1, `test_selector`=FIRST_SEL, `running`=0, `result_valid`=0, `result_sel`=0, `result_cycles`=0, `result_timeout`=0, `done`=0.
- States are IDLE, PRE, RUN, POST, DONE.
- IDLE: `cpu_reset`=1. On `start`, go to PRE with `test_selector`=FIRST_SEL and the index cleared.
- PRE: `cpu_reset`=1 for exactly RESET_CYCLES cycles, then go to RUN.
- RUN: `cpu_reset`=0 and `running`=1. The cycle counter is 1 in the first RUN cycle and increments each cycle.
  - If `halt`=1, latch count and timeout=0, then go to POST.
  - Else if count==RUN_CYCLES, latch count and timeout=1, then go to POST.
  - `halt` and the limit in the same cycle: halt wins, timeout=0.
- POST: one cycle with `cpu_reset`=1.
  - `result_valid`=1, with `result_sel`, `result_cycles` and `result_timeout` valid.
  - Result fields hold their value after the strobe until the next POST.
  - If index==NUM_TESTS-1, go to DONE. Otherwise increment `test_selector` and the index, then go to PRE.
- DONE: `cpu_reset`=1, `done`=1, `test_selector` holds the last value. On `start`, clear `done` and restart as from IDLE.
- Ignored inputs:
  - `start` is ignored in PRE, RUN and POST.
  - `halt` is ignored outside RUN.
- Precedence:
  - `reset` has priority over every input in every state.
  - A mid-sequence `reset` discards the current result, so no `result_valid` is produced, and forces `cpu_reset` high on the next cycle.
- Arithmetic:
  - The counter saturates by construction at RUN_CYCLES.
  - The selector increment never wraps, guaranteed by the elaboration check.

## Timing
- All outputs are registered and update on the rising `clk` edge. There are no combinational input-to-output paths.
- Latency of `start` to first PRE cycle: 1 cycle.
- Benchmark period without halt: RESET_CYCLES+RUN_CYCLES+1 cycles. With defaults this is 18 cycles, and a full sequence is 216 cycles.
- `halt` sampled in RUN cycle k gives `result_cycles`=k. POST follows the next edge, so `cpu_reset` rises 1 cycle after the halting RUN cycle.
- `done` rises in the cycle after the final POST.
- `test_selector` changes only on the PRE entry edge. It is therefore stable for the whole PRE/RUN/POST span of a benchmark, while `cpu_reset` is high at the change.

## Test plan
- Reset then idle: `reset` for 2 cycles, no `start` for 20 cycles. Outputs stay at their reset values: `cpu_reset`=1, `test_selector`=1, `done`=0.
- Full default sequence, `halt`=0: `start` at cycle 0.
  - 12 `result_valid` strobes, spaced 18 cycles apart.
  - `result_sel`=1..12, each with `result_cycles`=16 and `result_timeout`=1.
  - `done`=1 at cycle 217.
  - `cpu_reset` is low for exactly 16 cycles per benchmark.
- Early halt: pulse `halt` in the 5th RUN cycle of benchmark 3. Expect `result_sel`=3, `result_cycles`=5, `result_timeout`=0. The next PRE starts 2 cycles after the halt cycle.
- Halt on the limit cycle: `halt`=1 exactly in RUN cycle 16. Expect `result_cycles`=16 with `result_timeout`=0. A `halt` pulse during PRE or POST has no effect.
- Mid-run reset: assert `reset` in RUN cycle 7 of benchmark 2.
  - No strobe occurs.
  - On the next cycle: state IDLE, `cpu_reset`=1, `test_selector`=1.
  - A subsequent `start` restarts at selector 1.
- Parameter sweep: NUM_TESTS=3, FIRST_SEL=4, RESET_CYCLES=3, RUN_CYCLES=5.
  - Period is 9 cycles.
  - `result_sel` goes 4, 5, 6.
  - `start` during RUN is ignored.
  - `start` in DONE clears `done` and reruns the sequence.

Source files
------------

// File: rtl/benchmark_sequencer.sv
// rtl/benchmark_sequencer.sv - benchmark driver: steps test_selector, windows cpu reset, reports run results
//
// Steps test_selector from FIRST_SEL through FIRST_SEL+NUM_TESTS-1. For each
// benchmark the CPU is held in reset for RESET_CYCLES, released for at most
// RUN_CYCLES (ending early on halt), then put back in reset while the result
// is reported for one cycle.
//
// Ports:
//   clk            - single clock
//   reset          - synchronous active-high, returns to IDLE
//   start          - pulse in IDLE or DONE begins a sequence
//   halt           - CPU end-of-program, sampled only while running
//   cpu_reset      - drives cpu.reset
//   test_selector  - drives cpu.test_selector
//   running        - high while the CPU run window is open
//   result_valid   - one-cycle strobe per completed benchmark
//   result_sel     - selector of the reported benchmark
//   result_cycles  - run cycles consumed by the reported benchmark
//   result_timeout - reported run hit RUN_CYCLES without halt
//   done           - high after the last benchmark until start or reset
module benchmark_sequencer #(
  parameter int NUM_TESTS    = 12,
  parameter int SEL_W        = 4,
  parameter int FIRST_SEL    = 1,
  parameter int RESET_CYCLES = 1,
  parameter int RUN_CYCLES   = 16,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  output logic             cpu_reset,
  output logic [SEL_W-1:0] test_selector,
  output logic             running,
  output logic             result_valid,
  output logic [SEL_W-1:0] result_sel,
  output logic [CNT_W-1:0] result_cycles,
  output logic             result_timeout,
  output logic             done
);

  localparam int IDX_W = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;
  localparam int PRE_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;

  generate
    if (NUM_TESTS < 1) begin : g_bad_num_tests
      $error("NUM_TESTS must be at least 1");
    end
    if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
      $error("RESET_CYCLES must be at least 1");
    end
    if (RUN_CYCLES < 1) begin : g_bad_run_cycles
      $error("RUN_CYCLES must be at least 1");
    end
    if ((FIRST_SEL + NUM_TESTS - 1) >= (1 << SEL_W)) begin : g_bad_sel_range
      $error("FIRST_SEL+NUM_TESTS-1 does not fit in SEL_W");
    end
    if (RUN_CYCLES >= (1 << CNT_W)) begin : g_bad_cnt_w
      $error("RUN_CYCLES does not fit in CNT_W");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_RUN  = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] idx_q;
  logic [PRE_W-1:0] pre_cnt_q;
  logic [CNT_W-1:0] run_cnt_q;
  logic             last_idx;
  logic             run_limit;

  assign last_idx  = (idx_q == IDX_W'(NUM_TESTS - 1));
  assign run_limit = (run_cnt_q == CNT_W'(RUN_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_PRE;
      S_PRE:   if (pre_cnt_q == PRE_W'(RESET_CYCLES)) state_d = S_RUN;
      S_RUN:   if (halt || run_limit) state_d = S_POST;
      S_POST:  state_d = last_idx ? S_DONE : S_PRE;
      S_DONE:  if (start) state_d = S_PRE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one reflects the
  // state being entered, with no combinational path from the inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_reset      <= 1'b1;
      test_selector  <= SEL_W'(FIRST_SEL);
      running        <= 1'b0;
      result_valid   <= 1'b0;
      result_sel     <= '0;
      result_cycles  <= '0;
      result_timeout <= 1'b0;
      done           <= 1'b0;
      idx_q          <= '0;
      pre_cnt_q      <= '0;
      run_cnt_q      <= '0;
    end else begin
      cpu_reset    <= (state_d != S_RUN);
      running      <= (state_d == S_RUN);
      result_valid <= (state_d == S_POST);
      done         <= (state_d == S_DONE);

      if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
        test_selector <= SEL_W'(FIRST_SEL);
        idx_q         <= '0;
      end else if (state_q == S_POST && !last_idx) begin
        // Selector moves only on the POST->PRE edge, while cpu_reset is high.
        test_selector <= test_selector + SEL_W'(1);
        idx_q         <= idx_q + IDX_W'(1);
      end

      if (state_d == S_PRE && state_q != S_PRE) begin
        pre_cnt_q <= PRE_W'(1);
      end else if (state_q == S_PRE) begin
        pre_cnt_q <= pre_cnt_q + PRE_W'(1);
      end

      // Counter reads 1 in the first RUN cycle; leaving RUN at the limit
      // means it never exceeds RUN_CYCLES.
      if (state_d == S_RUN && state_q != S_RUN) begin
        run_cnt_q <= CNT_W'(1);
      end else if (state_q == S_RUN && state_d == S_RUN) begin
        run_cnt_q <= run_cnt_q + CNT_W'(1);
      end

      // Latch on the RUN->POST edge; halt takes precedence over the limit.
      if (state_q == S_RUN && state_d == S_POST) begin
        result_sel     <= test_selector;
        result_cycles  <= run_cnt_q;
        result_timeout <= !halt;
      end
    end
  end

endmodule

// File: tb/tb_benchmark_sequencer.sv
// tb/tb_benchmark_sequencer.sv - self-checking bench for benchmark_sequencer
module tb_benchmark_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, halt;
  logic       cpu_reset, running, result_valid, result_timeout, done;
  logic [3:0] test_selector, result_sel;
  logic [7:0] result_cycles;

  logic       reset_p, start_p, halt_p;
  logic       cpu_reset_p, running_p, result_valid_p, result_timeout_p, done_p;
  logic [3:0] test_selector_p, result_sel_p;
  logic [7:0] result_cycles_p;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int halt_at;
    int noise;
    int sel;
    int cycles;
    int timeout;
  } vec_t;

  vec_t vecs[24];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  benchmark_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .cpu_reset(cpu_reset), .test_selector(test_selector), .running(running),
    .result_valid(result_valid), .result_sel(result_sel),
    .result_cycles(result_cycles), .result_timeout(result_timeout), .done(done)
  );

  benchmark_sequencer #(
    .NUM_TESTS(3), .SEL_W(4), .FIRST_SEL(4), .RESET_CYCLES(3),
    .RUN_CYCLES(5), .CNT_W(8)
  ) dut_p (
    .clk(clk), .reset(reset_p), .start(start_p), .halt(halt_p),
    .cpu_reset(cpu_reset_p), .test_selector(test_selector_p), .running(running_p),
    .result_valid(result_valid_p), .result_sel(result_sel_p),
    .result_cycles(result_cycles_p), .result_timeout(result_timeout_p), .done(done_p)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic run_seq(input int first, input int count);
    int t0, exp_t, lo, k, got, hcyc;
    t0 = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_t = 0;
    for (int i = first; i < first + count; i++) begin
      lo = 0; k = 0; got = 0; hcyc = -1;
      exp_t += 1 + vecs[i].cycles + 1;
      for (int c = 0; c < 60 && got == 0; c++) begin
        if (!cpu_reset) lo++;
        if (running) begin
          k++;
          halt = (k == vecs[i].halt_at);
          if (halt) hcyc = cyc;
        end else begin
          halt = (vecs[i].noise != 0);
        end
        if (result_valid) begin
          got = 1;
          chk("result_sel", 32'(result_sel), 32'(vecs[i].sel));
          chk("result_cycles", 32'(result_cycles), 32'(vecs[i].cycles));
          chk("result_timeout", 32'(result_timeout), 32'(vecs[i].timeout));
          chk("strobe_cycle", 32'(cyc - t0), 32'(exp_t));
          chk("cpu_reset_low_cycles", 32'(lo), 32'(vecs[i].cycles));
          chk("post_cpu_reset", 32'(cpu_reset), 32'd1);
          if (hcyc >= 0) chk("halt_to_post", 32'(cyc - hcyc), 32'd1);
        end
        @(negedge clk);
      end
      if (got == 0) chk("strobe_timeout", 32'd0, 32'd1);
    end
    halt = 1'b0;
    chk("done", 32'(done), 32'd1);
    chk("done_cycle", 32'(cyc - t0), 32'(exp_t + 1));
  endtask

  task automatic run_p(input int start_in_run);
    int t0, exp_t, k, got;
    t0 = cyc;
    start_p = 1'b1;
    @(negedge clk);
    start_p = 1'b0;
    chk("p_done_cleared", 32'(done_p), 32'd0);
    exp_t = 0;
    for (int i = 0; i < 3; i++) begin
      k = 0; got = 0;
      exp_t += 3 + 5 + 1;
      for (int c = 0; c < 40 && got == 0; c++) begin
        if (running_p) begin
          k++;
          start_p = (start_in_run != 0 && i == 1 && k == 2);
        end else begin
          start_p = 1'b0;
        end
        if (result_valid_p) begin
          got = 1;
          chk("p_result_sel", 32'(result_sel_p), 32'(4 + i));
          chk("p_result_cycles", 32'(result_cycles_p), 32'd5);
          chk("p_result_timeout", 32'(result_timeout_p), 32'd1);
          chk("p_strobe_cycle", 32'(cyc - t0), 32'(exp_t));
        end
        @(negedge clk);
      end
      if (got == 0) chk("p_strobe_timeout", 32'd0, 32'd1);
    end
    start_p = 1'b0;
    chk("p_done", 32'(done_p), 32'd1);
    chk("p_done_cycle", 32'(cyc - t0), 32'd28);
  endtask

  initial begin
    int k, strobes, reached, seen;

    for (int i = 0; i < 12; i++) vecs[i] = '{0, 0, i + 1, 16, 1};
    for (int i = 12; i < 24; i++) vecs[i] = '{0, 1, i - 11, 16, 1};
    vecs[14] = '{5, 1, 3, 5, 0};
    vecs[15] = '{16, 1, 4, 16, 0};
    vecs[17] = '{1, 1, 6, 1, 0};

    reset = 1'b1; start = 1'b0; halt = 1'b0;
    reset_p = 1'b1; start_p = 1'b0; halt_p = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    reset_p = 1'b0;

    for (int c = 0; c < 20; c++) begin
      chk("idle_outputs",
          32'({cpu_reset, test_selector, running, result_valid, result_sel,
               result_cycles, result_timeout, done}),
          32'({1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0}));
      @(negedge clk);
    end
    chk("p_idle_selector", 32'(test_selector_p), 32'd4);
    chk("p_idle_cpu_reset", 32'(cpu_reset_p), 32'd1);

    run_seq(0, 12);
    run_seq(12, 12);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0; strobes = 0; reached = 0;
    for (int c = 0; c < 100 && reached == 0; c++) begin
      if (result_valid) begin
        strobes++;
        k = 0;
      end
      if (running) k++;
      if (strobes == 1 && k == 7) reached = 1;
      else @(negedge clk);
    end
    chk("midrun_reached", 32'(reached), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrun_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("midrun_selector", 32'(test_selector), 32'd1);
    chk("midrun_running", 32'(running), 32'd0);
    chk("midrun_valid", 32'(result_valid), 32'd0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (result_valid || !cpu_reset || done) seen++;
      @(negedge clk);
    end
    chk("midrun_stays_idle", 32'(seen), 32'd0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reached = 0;
    for (int c = 0; c < 40 && reached == 0; c++) begin
      if (result_valid) begin
        reached = 1;
        chk("restart_sel", 32'(result_sel), 32'd1);
        chk("restart_cycles", 32'(result_cycles), 32'd16);
      end
      @(negedge clk);
    end
    chk("restart_strobe_seen", 32'(reached), 32'd1);

    run_p(1);
    run_p(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
